alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Initiator side of the 1-bit ALU opcode interface: accepts WIDTH-bit operands plus a 4-bit function code, and drives the 1-bit ALU one 6-bit opcode {func, a_bit, b_bit} per cycle, LSB first.
- Collects the ALU's result/carry bits and assembles a WIDTH-bit result with carry, slt and iszero flags.
- Sits between the control path and the bit-serial ALU.

Parameters:
- WIDTH, 8, operand/result width in bits (min 2).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  4  function: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, NAND 1101
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- illegal  output  1  op was not a listed code; valid with done, held until next start
- result  output  WIDTH  assembled result; held until next accepted start
- carry_out  output  1  final carry for ADD/SUB; 0 for logic ops
- slt  output  1  signed a<b; SUB only, 0 otherwise
- iszero  output  1  result == 0, all legal ops
- alu_opcode  output  6  registered opcode to the ALU: [5:2] func, [1] a bit, [0] b bit
- alu_result  input  1  ALU result bit; combinational return, captured at the end of the issue cycle
- alu_carry  input  1  ALU carry bit; same timing as alu_result

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst.
  - rst takes priority over everything, including mid-operation.
  - On reset: state IDLE; busy, done, illegal, carry_out, slt, iszero = 0; result = 0; alu_opcode = 6'b000000; bit index and phase counters = 0.
- States: IDLE, ISSUE, FINISH.
  - IDLE + start with a legal op: latch a, b, op; go to ISSUE with bit=0, phase=0.
    - For SUB: b is latched inverted and cin = 1.
    - For ADD: cin = 0.
  - IDLE + start with an illegal op: go to FINISH directly with illegal=1 and result=0.
  - start while busy is ignored.
- ISSUE, logic ops:
  - One phase per bit; alu_opcode = {op, a[i], b[i]}.
  - Capture alu_result into result[i].
- ISSUE, ADD/SUB: three phases per bit i.
  - P0: {ADD, a[i], b'[i]}; capture s = alu_result, c1 = alu_carry.
  - P1: {ADD, s, cin}; capture result[i] = alu_result, c2 = alu_carry.
  - P2: {OR, c1, c2}; cin ← alu_result.
  - Before P2 of the MSB, the current cin is saved as c_msb_in.
- Bit index advances after the last phase of a bit. After bit WIDTH-1 completes, go to FINISH.
- FINISH lasts one cycle, then returns to IDLE:
  - done = 1 and busy = 0.
  - carry_out = cin.
  - iszero = ~|result.
  - slt (SUB) = result[WIDTH-1] ^ (c_msb_in ^ cin).
- alu_opcode returns to 6'b000000 in IDLE/FINISH.
- Latency, start-accept edge to done:
  - logic ops: WIDTH+1 cycles.
  - ADD/SUB: 3·WIDTH+1 cycles.
  - illegal op: 1 cycle.
- Boundaries:
  - Carry wrap: 0xFF+0x01 gives result 0, carry_out 1, iszero 1.
  - Back-to-back: start in the cycle after done is accepted.
  - Reset during ISSUE aborts with no done pulse.
- Output flags hold from FINISH until the next accepted start clears them.

Optional Feature:
- Macro: ALU_SEQ_FAST_CARRY_EN.
- When defined:
  - P2 is removed; cin ← c1 | c2 is computed locally at the end of P1.
  - ADD/SUB latency becomes 2·WIDTH+1.
- When undefined: three-phase behaviour above, so every carry combine goes through the ALU.
- Results and flags are identical in both builds.

Decomposition:
- Package alu_seq_pkg holds:
  - the func code constants (AND, OR, ADD, SUB, NOR, NAND) as 4-bit localparams;
  - the state enum (IDLE/ISSUE/FINISH);
  - the phase enum (P0/P1/P2).
- One natural sub-module, alu_seq_opfmt: a combinational packer giving func, bit a, bit b → 6-bit opcode.
- The top contains the FSM, counters and result shift/capture.
- Bench instantiates the existing 1-bit ALU as the responder.

Test Plan:
- Arithmetic cases, all with WIDTH=8:
  - ADD a=0x7F b=0x01 → done 25 cycles after accept; result 0x80, carry_out 0, iszero 0, slt 0, illegal 0.
  - ADD a=0xFF b=0x01 → result 0x00, carry_out 1, iszero 1.
  - SUB a=0x03 b=0x05 → result 0xFE, carry_out 0, slt 1.
  - SUB a=0x05 b=0x05 → result 0x00, carry_out 1, iszero 1, slt 0.
- AND a=0xF0 b=0x3C → done 9 cycles after accept, result 0x30.
  - Then NOR with the same operands → 0x03.
  - Then NAND with the same operands → 0xCF.
  - Check the alu_opcode sequence bit-by-bit.
- op=4'b1111 → done next cycle, illegal 1, result 0x00, alu_opcode stays 0.
- rst asserted mid-ADD (cycle 10):
  - Next cycle busy 0, done 0, alu_opcode 0.
  - A following ADD 0x02+0x03 gives 0x05.
  - start pulsed while busy is ignored.
- Rebuild with ALU_SEQ_FAST_CARRY_EN: repeat the ADD/SUB cases → same results, done 17 cycles after accept.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: func codes, FSM/phase enums and op classification for the bit-serial ALU sequencer.
package alu_seq_pkg;
  localparam logic [3:0] FN_AND  = 4'b0000;
  localparam logic [3:0] FN_OR   = 4'b0001;
  localparam logic [3:0] FN_ADD  = 4'b0010;
  localparam logic [3:0] FN_SUB  = 4'b0110;
  localparam logic [3:0] FN_NOR  = 4'b1100;
  localparam logic [3:0] FN_NAND = 4'b1101;
  typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_e;
  typedef enum logic [1:0] {P0, P1, P2} phase_e;
  function automatic logic is_arith(input logic [3:0] f);
    return f == FN_ADD || f == FN_SUB;
  endfunction
  function automatic logic is_legal(input logic [3:0] f);
    return is_arith(f) || f == FN_AND || f == FN_OR || f == FN_NOR || f == FN_NAND;
  endfunction
endpackage

// File: rtl/alu_seq_opfmt.sv
// alu_seq_opfmt: packs func and operand bits into the 6-bit ALU opcode.
module alu_seq_opfmt
  import alu_seq_pkg::*;
(
  input  logic [3:0] func_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic [5:0] opcode_o
);
  assign opcode_o = {func_i, a_i, b_i};
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives a 1-bit ALU LSB first and assembles a WIDTH-bit result with flags.
// ALU_SEQ_FAST_CARRY_EN folds the carry combine locally, dropping the third phase per bit.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             slt,
  output logic             iszero,
  output logic [5:0]       alu_opcode,
  input  logic             alu_result,
  input  logic             alu_carry
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
`ifdef ALU_SEQ_FAST_CARRY_EN
  localparam phase_e LAST_PH = P1;
`else
  localparam phase_e LAST_PH = P2;
`endif
  state_e state_q, state_d;
  phase_e phase_q, phase_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0] op_q, op_d, fn_d;
  logic s_q, s_d, c1_q, c1_d, c2_q, c2_d, cin_q, cin_d;
  logic ill_q, ill_d, cout_q, cout_d, slt_q, slt_d, zero_q, zero_d;
  logic [5:0] opc_q, opc_d, opc_n;
  logic arith, arith_d, bit_done, ab_d, bb_d;
  assign arith    = is_arith(op_q);
  assign arith_d  = is_arith(op_d);
  assign bit_done = ~arith | (phase_q == LAST_PH);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= P0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE  ? (start ? (is_legal(op) ? ISSUE : FINISH) : IDLE) :
              state_q == ISSUE ? ((bit_done && bit_q == LAST) ? FINISH : ISSUE) : IDLE;
  end
  always_comb begin
    phase_d = phase_q;
    bit_d   = bit_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    s_d     = s_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    cin_d   = cin_q;
    ill_d   = ill_q;
    cout_d  = cout_q;
    slt_d   = slt_q;
    zero_d  = zero_q;
    if (state_q == IDLE && start) begin
      a_d     = a;
      b_d     = op == FN_SUB ? ~b : b;
      op_d    = op;
      cin_d   = op == FN_SUB;
      res_d   = '0;
      phase_d = P0;
      bit_d   = '0;
      ill_d   = ~is_legal(op);
      cout_d  = 1'b0;
      slt_d   = 1'b0;
      zero_d  = 1'b0;
    end else if (state_q == ISSUE) begin
      if (!arith) res_d[bit_q] = alu_result;
      else if (phase_q == P0) begin
        s_d     = alu_result;
        c1_d    = alu_carry;
        phase_d = P1;
      end else if (phase_q == P1) begin
        res_d[bit_q] = alu_result;
        c2_d         = alu_carry;
`ifdef ALU_SEQ_FAST_CARRY_EN
        cin_d        = c1_q | alu_carry;
        phase_d      = P0;
`else
        phase_d      = P2;
`endif
      end else begin
        cin_d   = alu_result;
        phase_d = P0;
      end
      if (bit_done) bit_d = bit_q + BW'(1);
      // cin_q is still the carry into the MSB here, cin_d the carry out of it
      if (state_d == FINISH) begin
        cout_d = arith & cin_d;
        zero_d = ~|res_d;
        slt_d  = (op_q == FN_SUB) & (res_d[WIDTH-1] ^ cin_q ^ cin_d);
      end
    end
  end
  always_comb begin
    fn_d  = !arith_d ? op_d : (phase_d == P2 ? FN_OR : FN_ADD);
    ab_d  = phase_d == P1 ? s_d   : phase_d == P2 ? c1_d : a_d[bit_d];
    bb_d  = phase_d == P1 ? cin_d : phase_d == P2 ? c2_d : b_d[bit_d];
    opc_d = state_d == ISSUE ? opc_n : '0;
  end
  alu_seq_opfmt u_opfmt (
    .func_i   (fn_d),
    .a_i      (ab_d),
    .b_i      (bb_d),
    .opcode_o (opc_n)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      s_q    <= 1'b0;
      c1_q   <= 1'b0;
      c2_q   <= 1'b0;
      cin_q  <= 1'b0;
      ill_q  <= 1'b0;
      cout_q <= 1'b0;
      slt_q  <= 1'b0;
      zero_q <= 1'b0;
      opc_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      res_q  <= res_d;
      s_q    <= s_d;
      c1_q   <= c1_d;
      c2_q   <= c2_d;
      cin_q  <= cin_d;
      ill_q  <= ill_d;
      cout_q <= cout_d;
      slt_q  <= slt_d;
      zero_q <= zero_d;
      opc_q  <= opc_d;
    end
  end
  always_comb begin
    busy       = state_q == ISSUE;
    done       = state_q == FINISH;
    illegal    = ill_q;
    result     = res_q;
    carry_out  = cout_q;
    slt        = slt_q;
    iszero     = zero_q;
    alu_opcode = opc_q;
  end
endmodule
